hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage core; sits beside the forwarding unit and drives all stage stall/flush enables.
- Resolves load-use hazards, taken-branch flushes and data-memory wait states.
- Sequences the multi-cycle multiply/divide unit (MDU) through a start/done handshake.
- Owns a saturating stall-cycle counter and a sticky MDU-timeout flag.

Parameters:
CNT_W, 32, width of StallCycles counter
MDU_TIMEOUT, 64, MDU_BUSY cycles after which MduErr sets (1..2^16-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Rs1D  input  5  source reg 1 of instruction in Decode
Rs2D  input  5  source reg 2 of instruction in Decode
RdE  input  5  destination reg of instruction in Execute
ResultSrcE0  input  1  instruction in Execute is a load
PCSrcE  input  1  taken branch/jump resolved in Execute
MduOpE  input  1  instruction in Execute is a multi-cycle MDU op
MduDone  input  1  MDU result valid this cycle (single-cycle pulse)
MemReqM  input  1  Memory-stage instruction accesses data memory
MemReadyM  input  1  data memory completes access this cycle
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
StallM  output  1  hold EX/MEM register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  clear EX/MEM register (insert bubble)
FlushW  output  1  clear MEM/WB register (insert bubble)
MduStart  output  1  one-cycle MDU start pulse
StallCycles  output  CNT_W  count of cycles with StallF=1, saturating
MduErr  output  1  sticky: MDU exceeded MDU_TIMEOUT

Behaviour:
- Stall/flush/MduStart outputs are combinational from state and inputs; StallCycles, MduErr and state are registered.
- Reset: state=RUN, StallCycles=0, MduErr=0, MDU wait counter=0.
  - With reset high, all stall/flush/MduStart outputs are 0 regardless of inputs.
  - Reset mid-MDU or mid-MEM_WAIT aborts to RUN; the MDU shares the same reset.
- memstall = MemReqM & ~MemReadyM.
- lwstall = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- States: RUN, MDU_BUSY, MEM_WAIT. Priority in RUN: memstall > MduOpE > lwstall > PCSrcE.
- RUN, memstall=1:
  - StallF/D/E/M=1, FlushW=1, MduStart=0; branch flush and load-use suppressed.
  - Next state MEM_WAIT.
- RUN, memstall=0, MduOpE=1:
  - MduStart=1 (exactly this cycle), StallF/D/E=1, FlushM=1.
  - Next state MDU_BUSY; wait counter cleared to 0.
- RUN, neither of the above:
  - lwstall -> StallF=1, StallD=1, FlushE=1.
  - PCSrcE -> FlushD=1, FlushE=1.
  - Both lwstall and PCSrcE -> FlushD=1, FlushE=1, StallF=0, StallD=0 (branch wins; the Decode instruction is discarded).
- MEM_WAIT:
  - memstall=1 -> StallF/D/E/M=1, FlushW=1, stay.
  - memstall=0 -> act exactly as RUN for this cycle's combinational outputs (MduOpE/lwstall/PCSrcE now evaluated); next state per RUN rules.
  - Latency: the access completes the cycle MemReadyM=1, with no extra bubble.
- MDU_BUSY:
  - MduDone=0 -> StallF/D/E=1, FlushM=1, MduStart=0; wait counter increments.
  - MduDone=1 -> no stall/flush, E advances with result; next state RUN.
  - No new MduStart is issued until the state returns to RUN with MduOpE=1 for a new instruction.
  - The MDU occupies E, so neither lwstall nor PCSrcE is acted on in this state.
  - When the wait counter reaches MDU_TIMEOUT, MduErr sets and holds until reset; the state keeps waiting for MduDone.
- StallCycles increments by 1 on every clock with StallF=1 and reset=0; it holds at all-ones once saturated.
- Invariants (assertion-checkable):
  - Never FlushE & StallE.
  - Never FlushD & StallD.
  - MduStart is never high two consecutive cycles.
  - StallM implies StallE.

Test Plan:
- Load-use: ResultSrcE0=1, RdE=5, Rs1D=5, no other events -> one cycle StallF=StallD=FlushE=1; RdE=0 with Rs1D=0 -> no stall.
- Branch: PCSrcE=1 in RUN -> FlushD=FlushE=1 for one cycle; PCSrcE with lwstall -> FlushD=FlushE=1, StallF=StallD=0.
- MDU: MduOpE=1, MduDone after 4 cycles -> MduStart high only in cycle 0; StallF/D/E=FlushM=1 for cycles 0-3; all 0 in cycle 4; StallCycles +4.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, PCSrcE=1 throughout -> StallF/D/E/M=FlushW=1 for 3 cycles with FlushD/E=0; on the ready cycle FlushD=FlushE=1.
- Timeout: MDU_TIMEOUT=8, MduDone withheld 10 cycles -> MduErr rises after cycle 8 and stays 1 after MduDone; clears only on reset.
- Reset mid-MDU_BUSY (cycle 2) -> next cycle all outputs 0, StallCycles=0, state RUN; with CNT_W=4 and a held stall, StallCycles saturates at 15.

Source files
------------

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// HazardController: pipeline sequencing controller for the 5-stage core.
//
// Purpose:
//   Drives every stage stall/flush enable. It resolves load-use hazards,
//   taken-branch flushes and data-memory wait states. It sequences the
//   multi-cycle multiply/divide unit (MDU) through a start/done handshake.
//   It also keeps a saturating count of fetch-stall cycles and a sticky
//   MDU-timeout flag.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   Rs1D, Rs2D            source registers of the Decode instruction
//   RdE, ResultSrcE0      destination register / is-load of the Execute instr
//   PCSrcE                taken branch/jump resolved in Execute
//   MduOpE, MduDone       MDU op in Execute / MDU result-valid pulse
//   MemReqM, MemReadyM    data-memory request / completion in Memory stage
//   StallF/D/E/M          hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/M/W          clear IF/ID, ID/EX, EX/MEM, MEM/WB
//   MduStart              one-cycle MDU start pulse
//   StallCycles           saturating count of cycles with StallF=1
//   MduErr                sticky flag: MDU exceeded MDU_TIMEOUT wait cycles
// ---------------------------------------------------------------------------
module hazard_controller #(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MduOpE,
  input  logic             MduDone,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MduStart,
  output logic [CNT_W-1:0] StallCycles,
  output logic             MduErr
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } stateT;

  stateT             state_q, state_d;
  logic [15:0]       waitCnt_q, waitCnt_d;
  logic              mduErr_q, mduErr_d;
  logic [CNT_W-1:0]  stallCycles_q, stallCycles_d;

  logic              memStall;
  logic              lwStall;
  logic [16:0]       waitInc;
  logic              timeoutHit;

  // Hazard detection terms. A load into x0 never creates a dependency.
  assign memStall = MemReqM & ~MemReadyM;
  assign lwStall  = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // The wait counter is widened by one bit so the increment cannot wrap,
  // even with the largest timeout. The counter stops at MDU_TIMEOUT.
  assign waitInc    = {1'b0, waitCnt_q} + 17'd1;
  assign timeoutHit = (waitInc >= 17'(MDU_TIMEOUT));

  // Next-state and output decode. MEM_WAIT falls through to the RUN rules
  // once memory is ready, so the completing cycle costs no extra bubble.
  // While reset is high, every enable is forced low whatever the inputs are.
  always_comb begin
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    StallM        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    FlushM        = 1'b0;
    FlushW        = 1'b0;
    MduStart      = 1'b0;
    state_d       = state_q;
    waitCnt_d     = waitCnt_q;
    mduErr_d      = mduErr_q;
    stallCycles_d = stallCycles_q;

    if (!reset) begin
      case (state_q)
        MDU_BUSY: begin
          // The MDU occupies Execute, so branch and load-use are ignored here.
          if (!MduDone) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
            waitCnt_d = timeoutHit ? 16'(MDU_TIMEOUT) : waitInc[15:0];
            if (timeoutHit) begin
              mduErr_d = 1'b1;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          if (memStall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            StallM  = 1'b1;
            FlushW  = 1'b1;
            state_d = MEM_WAIT;
          end else if (MduOpE) begin
            MduStart  = 1'b1;
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
            waitCnt_d = 16'd0;
            state_d   = MDU_BUSY;
          end else begin
            state_d = RUN;
            // A taken branch discards the Decode instruction, so a
            // concurrent load-use stall on it is pointless.
            if (PCSrcE) begin
              FlushD = 1'b1;
              FlushE = 1'b1;
            end else if (lwStall) begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
            end
          end
        end
      endcase

      if (StallF && (stallCycles_q != {CNT_W{1'b1}})) begin
        stallCycles_d = stallCycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // State, counters and sticky error flag, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      waitCnt_q     <= 16'd0;
      mduErr_q      <= 1'b0;
      stallCycles_q <= '0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      mduErr_q      <= mduErr_d;
      stallCycles_q <= stallCycles_d;
    end
  end

  assign StallCycles = stallCycles_q;
  assign MduErr      = mduErr_q;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// TbHazardController: directed, self-checking bench for hazard_controller.
// Built with CNT_W=4 and MDU_TIMEOUT=8 so that saturation and timeout can
// be reached in a few cycles. Outputs are sampled on the falling edge.
// The enable vector is packed as {F,D,E,M,fD,fE,fM,fW,start}.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int CNT_W = 4;

  localparam logic [8:0] NONE    = 9'b000000000;
  localparam logic [8:0] LOADUSE = 9'b110001000;
  localparam logic [8:0] BRANCH  = 9'b000011000;
  localparam logic [8:0] MDUGO   = 9'b111000101;
  localparam logic [8:0] MDUWAIT = 9'b111000100;
  localparam logic [8:0] MEMWAIT = 9'b111100010;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, RdE;
  logic             ResultSrcE0, PCSrcE, MduOpE, MduDone, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW, MduStart, MduErr;
  logic [CNT_W-1:0] StallCycles;
  logic [8:0]       outs;

  int checks   = 0;
  int failures = 0;
  logic prevStart = 1'b0;

  hazard_controller #(.CNT_W(CNT_W), .MDU_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MduOpE(MduOpE), .MduDone(MduDone),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MduStart(MduStart), .StallCycles(StallCycles), .MduErr(MduErr)
  );

  always #5 clk = ~clk;

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduStart};

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one full set of inputs.
  task automatic applyStimulus(input logic rst, input logic mduOp, input logic mduDone,
                               input logic memReq, input logic memReady,
                               input logic pcSrc, input logic load,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2);
    reset       = rst;
    MduOpE      = mduOp;
    MduDone     = mduDone;
    MemReqM     = memReq;
    MemReadyM   = memReady;
    PCSrcE      = pcSrc;
    ResultSrcE0 = load;
    RdE         = rd;
    Rs1D        = rs1;
    Rs2D        = rs2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants checked every cycle on the sampling edge.
  always @(negedge clk) begin
    checkOutput("inv_flushE_stallE", 32'(FlushE & StallE), 32'd0);
    checkOutput("inv_flushD_stallD", 32'(FlushD & StallD), 32'd0);
    checkOutput("inv_stallM_implies_stallE", 32'(StallM & ~StallE), 32'd0);
    checkOutput("inv_start_twice", 32'(MduStart & prevStart), 32'd0);
    prevStart = MduStart;
  end

  initial begin
    idle();
    reset = 1'b1;
    tick();

    // Reset held with every hazard input asserted: all enables low.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    settle();
    checkOutput("reset_outs", 32'(outs), 32'(NONE));
    tick();
    idle();
    settle();
    checkOutput("post_reset_outs", 32'(outs), 32'(NONE));
    checkOutput("post_reset_cnt", 32'(StallCycles), 32'd0);
    checkOutput("post_reset_err", 32'(MduErr), 32'd0);
    tick();

    // Load-use on Rs1 and on Rs2, each for one cycle only.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
    settle();
    checkOutput("loaduse_rs1", 32'(outs), 32'(LOADUSE));
    tick();
    idle();
    settle();
    checkOutput("loaduse_released", 32'(outs), 32'(NONE));
    checkOutput("loaduse_cnt", 32'(StallCycles), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7);
    settle();
    checkOutput("loaduse_rs2", 32'(outs), 32'(LOADUSE));
    tick();
    // Load into x0 never stalls; a load with no matching source never stalls.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("loaduse_x0", 32'(outs), 32'(NONE));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd2);
    settle();
    checkOutput("loaduse_nomatch", 32'(outs), 32'(NONE));
    checkOutput("loaduse_cnt2", 32'(StallCycles), 32'd2);
    tick();

    // Branch alone, then branch together with a load-use hazard.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("branch", 32'(outs), 32'(BRANCH));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
    settle();
    checkOutput("branch_over_loaduse", 32'(outs), 32'(BRANCH));
    tick();
    idle();
    settle();
    checkOutput("branch_cnt", 32'(StallCycles), 32'd2);
    tick();

    // MDU op completing on cycle 4; a branch during busy must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("mdu_c0", 32'(outs), 32'(MDUGO));
    tick();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
      settle();
      checkOutput($sformatf("mdu_c%0d", c), 32'(outs), 32'(MDUWAIT));
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("mdu_c4_done", 32'(outs), 32'(NONE));
    tick();
    idle();
    settle();
    checkOutput("mdu_after", 32'(outs), 32'(NONE));
    checkOutput("mdu_cnt", 32'(StallCycles), 32'd6);
    tick();

    // Memory wait for 3 cycles with a pending branch, then ready.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      settle();
      checkOutput($sformatf("memwait_c%0d", c), 32'(outs), 32'(MEMWAIT));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("memwait_ready", 32'(outs), 32'(BRANCH));
    tick();
    idle();
    settle();
    checkOutput("memwait_cnt", 32'(StallCycles), 32'd9);
    tick();

    // Timeout: MduDone withheld for 10 busy cycles with MDU_TIMEOUT=8.
    reset = 1'b1;
    tick();
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      settle();
      checkOutput($sformatf("timeout_err_k%0d", k), 32'(MduErr), (k >= 8) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    idle();
    settle();
    checkOutput("timeout_err_after_done", 32'(MduErr), 32'd1);
    checkOutput("timeout_outs_after_done", 32'(outs), 32'(NONE));
    checkOutput("timeout_cnt", 32'(StallCycles), 32'd11);
    tick();
    reset = 1'b1;
    tick();
    idle();
    settle();
    checkOutput("timeout_err_cleared", 32'(MduErr), 32'd0);
    tick();

    // Reset asserted during the second busy cycle aborts back to RUN.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("midmdu_reset_outs", 32'(outs), 32'(NONE));
    tick();
    idle();
    settle();
    checkOutput("midmdu_after_outs", 32'(outs), 32'(NONE));
    checkOutput("midmdu_after_cnt", 32'(StallCycles), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("midmdu_restart_in_run", 32'(outs), 32'(MDUGO));
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();

    // Saturation: 20 memory-stall cycles on a 4-bit counter stop at 15.
    reset = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
    end
    settle();
    checkOutput("sat_cnt", 32'(StallCycles), 32'd15);
    checkOutput("sat_outs", 32'(outs), 32'(MEMWAIT));
    tick();
    settle();
    checkOutput("sat_cnt_hold", 32'(StallCycles), 32'd15);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
